// File: rtl/i2s_capture_rx.sv
// I2S record-path receiver running entirely on mclk.
// Oversamples bclk/reclrc/recdat, deserialises MSB-first words with the I2S one-bit delay,
// pairs left/right into frames and presents them over a valid/ready handshake.
// Optional peak meter: define I2S_RX_PEAK_EN to build it; otherwise peak_level is tied to 0.
module i2s_capture_rx #(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 16
) (
  input  logic                          mclk,
  input  logic                          rst_n,
  input  logic                          audio_I2S_bclk,
  input  logic                          audio_I2S_reclrc,
  input  logic                          audio_I2S_recdat,
  output logic signed [SAMPLE_BITS-1:0] rx_left,
  output logic signed [SAMPLE_BITS-1:0] rx_right,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  output logic                          rx_frame_err,
  output logic        [SAMPLE_BITS-1:0] peak_level,
  input  logic                          peak_clr
);

  localparam int CW = $clog2(SLOT_BITS + 2);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOT_BITS);
  localparam logic [CW-1:0] SAMP_C = CW'(SAMPLE_BITS);
  localparam logic [CW-1:0] SAT_C  = CW'(SLOT_BITS + 1);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic bclk_p0, bclk_p1, bclk_p2;
  logic lrc_p0, lrc_p1;
  logic dat_p0, dat_p1;

  logic                          state;
  logic                          lrc_prev;
  logic [CW-1:0]                 slot_cnt;
  logic signed [SAMPLE_BITS-1:0] shift_reg;
  logic signed [SAMPLE_BITS-1:0] left_hold;
  logic                          left_vld;

  logic                          frm_vld_p2;
  logic signed [SAMPLE_BITS-1:0] frm_left_p2;
  logic signed [SAMPLE_BITS-1:0] frm_right_p2;

  logic                          rise_p1;
  logic                          boundary_p1;
  logic                          slot_ok_p1;
  logic signed [SAMPLE_BITS-1:0] word_close_p1;

  // Stage p0/p1: two-flop synchronisers; bclk_p2 is the previous synchronised bclk for edge detect
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_p0 <= 1'b0;
      bclk_p1 <= 1'b0;
      bclk_p2 <= 1'b0;
      lrc_p0  <= 1'b0;
      lrc_p1  <= 1'b0;
      dat_p0  <= 1'b0;
      dat_p1  <= 1'b0;
    end else begin
      bclk_p0 <= audio_I2S_bclk;
      bclk_p1 <= bclk_p0;
      bclk_p2 <= bclk_p1;
      lrc_p0  <= audio_I2S_reclrc;
      lrc_p1  <= lrc_p0;
      dat_p0  <= audio_I2S_recdat;
      dat_p1  <= dat_p0;
    end
  end

  // The boundary bit is the LSB of the closing slot, so the closing word includes dat_p1
  // whenever that bit still falls inside the sample width.
  assign rise_p1       = bclk_p1 & ~bclk_p2;
  assign boundary_p1   = rise_p1 & (lrc_p1 != lrc_prev);
  assign slot_ok_p1    = (slot_cnt == SLOT_C);
  assign word_close_p1 = (slot_cnt <= SAMP_C) ? {shift_reg[SAMPLE_BITS-2:0], dat_p1} : shift_reg;

  // Stage p1 -> p2: slot counting, word assembly, L/R pairing and slot-length checking
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_SYNC;
      lrc_prev     <= 1'b0;
      slot_cnt     <= '0;
      shift_reg    <= '0;
      left_hold    <= '0;
      left_vld     <= 1'b0;
      frm_vld_p2   <= 1'b0;
      frm_left_p2  <= '0;
      frm_right_p2 <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      frm_vld_p2   <= 1'b0;
      rx_frame_err <= 1'b0;
      if (rise_p1) begin
        lrc_prev <= lrc_p1;
        if (state == ST_SYNC) begin
          if (boundary_p1) begin
            state     <= ST_RUN;
            slot_cnt  <= CW'(1);
            shift_reg <= '0;
            left_vld  <= 1'b0;
          end
        end else if (boundary_p1) begin
          slot_cnt  <= CW'(1);
          shift_reg <= '0;
          if (slot_ok_p1) begin
            if (!lrc_prev) begin
              left_hold <= word_close_p1;
              left_vld  <= 1'b1;
            end else begin
              if (left_vld) begin
                frm_vld_p2   <= 1'b1;
                frm_left_p2  <= left_hold;
                frm_right_p2 <= word_close_p1;
              end
              left_vld <= 1'b0;
            end
          end else begin
            rx_frame_err <= 1'b1;
            left_vld     <= 1'b0;
          end
        end else begin
          if (slot_cnt <= SAMP_C) shift_reg <= {shift_reg[SAMPLE_BITS-2:0], dat_p1};
          if (slot_cnt != SAT_C) slot_cnt <= slot_cnt + 1'b1;
        end
      end
    end
  end

  // Stage p2 -> output: frame hold register with handshake and overrun detection
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_left    <= '0;
      rx_right   <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (frm_vld_p2) begin
        rx_left    <= frm_left_p2;
        rx_right   <= frm_right_p2;
        rx_valid   <= 1'b1;
        rx_overrun <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_PEAK_EN
  logic                          wrd_vld_p2;
  logic signed [SAMPLE_BITS-1:0] wrd_p2;
  logic        [SAMPLE_BITS-1:0] wrd_mag_p2;

  // Magnitude with the most negative code saturated to the largest positive code
  function automatic logic [SAMPLE_BITS-1:0] mag_sat(input logic signed [SAMPLE_BITS-1:0] w);
    if (w == {1'b1, {(SAMPLE_BITS-1){1'b0}}}) return {1'b0, {(SAMPLE_BITS-1){1'b1}}};
    else if (w[SAMPLE_BITS-1])                return $unsigned(-w);
    else                                      return $unsigned(w);
  endfunction

  assign wrd_mag_p2 = mag_sat(wrd_p2);

  // Stage p1 -> p2: capture every well-formed closing word for the meter
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      wrd_vld_p2 <= 1'b0;
      wrd_p2     <= '0;
    end else begin
      wrd_vld_p2 <= 1'b0;
      if (rise_p1 && state == ST_RUN && boundary_p1 && slot_ok_p1) begin
        wrd_vld_p2 <= 1'b1;
        wrd_p2     <= word_close_p1;
      end
    end
  end

  // Peak hold; a clear coinciding with a new word reloads from that word alone
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      peak_level <= '0;
    end else if (wrd_vld_p2) begin
      if (peak_clr || wrd_mag_p2 > peak_level) peak_level <= wrd_mag_p2;
    end else if (peak_clr) begin
      peak_level <= '0;
    end
  end
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_level      = '0;
`endif

endmodule
